// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between the execute stage (port 0)
// and the microcode unit (port 1): issue for one cycle, capture the result, pulse done.
module alu_arbiter #(
    parameter int         W      = 16,
    parameter logic [7:0] OP_MAX = 8'h11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_req,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    input  logic [7:0]   r0_op,
    input  logic         r0_cf,
    output logic         r0_ack,
    output logic         r0_done,
    output logic         r0_err,
    input  logic         r1_req,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    input  logic [7:0]   r1_op,
    input  logic         r1_cf,
    output logic         r1_ack,
    output logic         r1_done,
    output logic         r1_err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [7:0]   alu_op,
    output logic         alu_cf,
    input  logic [W-1:0] alu_acc,
    input  logic [W-1:0] alu_c,
    input  logic         alu_cflag,
    input  logic         alu_zflag,
    input  logic         alu_oflag,
    output logic [W-1:0] rsp_acc,
    output logic [W-1:0] rsp_c,
    output logic         rsp_cf,
    output logic         rsp_zf,
    output logic         rsp_of,
    output logic         rsp_id,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t     state, state_nx;
    logic       last_grant;
    logic       sel;
    logic [7:0] op_q;
    logic [1:0] done_q;

    logic       any_req;
    logic       grant_id;
    logic [7:0] grant_op;
    logic       illegal;
    logic       take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        any_req  = r0_req | r1_req;
        grant_id = (r0_req && r1_req) ? ~last_grant : r1_req;
        grant_op = grant_id ? r1_op : r0_op;
        illegal  = (grant_op == 8'h00) || (grant_op > OP_MAX);
        // NOTE: accept is gated by rst so a held request is not acked while reset holds the block.
        take     = (state == IDLE) && any_req && !rst;

        state_nx = state;
        r0_ack   = take && !grant_id;
        r1_ack   = take && grant_id;
        r0_err   = r0_ack && illegal;
        r1_err   = r1_ack && illegal;
        alu_op   = 8'h00;
        busy     = (state != IDLE);

        case (state)
            IDLE:    if (take && !illegal) state_nx = ISSUE;
            ISSUE: begin
                alu_op   = op_q;
                state_nx = WAIT;
            end
            WAIT:    state_nx = CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            sel        <= 1'b0;
            op_q       <= 8'h00;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cf     <= 1'b0;
            rsp_acc    <= '0;
            rsp_c      <= '0;
            rsp_cf     <= 1'b0;
            rsp_zf     <= 1'b0;
            rsp_of     <= 1'b0;
            rsp_id     <= 1'b0;
            done_q     <= 2'b00;
        end else begin
            done_q <= 2'b00;
            // Operands are latched even for an illegal op; op_q never reaches the ALU in that case.
            if (take) begin
                alu_a      <= grant_id ? r1_a : r0_a;
                alu_b      <= grant_id ? r1_b : r0_b;
                alu_cf     <= grant_id ? r1_cf : r0_cf;
                op_q       <= grant_op;
                last_grant <= grant_id;
                sel        <= grant_id;
            end
            if (state == CAPTURE) begin
                rsp_acc <= alu_acc;
                rsp_c   <= alu_c;
                rsp_cf  <= alu_cflag;
                rsp_zf  <= alu_zflag;
                rsp_of  <= alu_oflag;
                rsp_id  <= sel;
                done_q  <= sel ? 2'b10 : 2'b01;
            end
        end
    end

    assign r0_done = done_q[0];
    assign r1_done = done_q[1];

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered 16-bit ALU between two requesters: port 0 is the core execute stage, port 1 is the auxiliary/microcode unit.
- Arbitrates round-robin and latches the winner's operands.
- Drives the ALU for exactly one issue cycle, then captures acc, c and flags into a shared response register.
- Pulses done to the winner. Holds ALU op at 8'h00 (no-op, ALU state preserved) whenever idle.

Parameters:
- W, 16, operand/result width; must match the ALU.
- OP_MAX, 8'h11, highest legal ALU opcode; legal range is 8'h01..OP_MAX.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- r0_req  in  1  requester 0 request, held until r0_ack
- r0_a, r0_b  in  W  requester 0 operands
- r0_op  in  8  requester 0 ALU opcode
- r0_cf  in  1  requester 0 carry-in for ADC/SUC
- r0_ack  out  1  one-cycle accept pulse
- r0_done  out  1  one-cycle result-valid pulse
- r0_err  out  1  one-cycle illegal-opcode pulse
- r1_req, r1_a, r1_b, r1_op, r1_cf, r1_ack, r1_done, r1_err: same as port 0, for requester 1
- alu_a, alu_b  out  W  to ALU a/b
- alu_op  out  8  to ALU op
- alu_cf  out  1  to ALU cf
- alu_acc, alu_c  in  W  from ALU acc/c
- alu_cflag, alu_zflag, alu_oflag  in  1  from ALU flags
- rsp_acc, rsp_c  out  W  captured result
- rsp_cf, rsp_zf, rsp_of  out  1  captured flags
- rsp_id  out  1  requester that owns the current rsp_* contents
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - All outputs 0, including alu_op=8'h00.
- FSM states: IDLE -> ISSUE -> WAIT -> CAPTURE -> IDLE.
- IDLE:
  - If only one req is high, select it. If both are high, select the port != last_grant.
  - On selection: pulse rX_ack, latch a/b/op/cf into alu_a/alu_b/op_q/alu_cf, set last_grant and sel.
  - If the latched op is 0 or >OP_MAX: pulse rX_err in the same cycle as ack, stay in IDLE, drive no ALU op, leave rsp_* unchanged. Otherwise go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle): alu_op=op_q; the ALU samples at the end of this cycle. Next state WAIT.
- WAIT (1 cycle): alu_op=8'h00; ALU outputs settle. Next state CAPTURE.
- CAPTURE (1 cycle):
  - Register rsp_acc<=alu_acc, rsp_c<=alu_c, flags<=alu_*flag, rsp_id<=sel.
  - Pulse rX_done for the selected port in the following cycle, coincident with the new rsp_* values.
  - Next state IDLE.
- alu_op is nonzero only in ISSUE; every other cycle drives 8'h00.
- Latency: ack at cycle T, ALU issue at T+1, done at T+4 (done and new rsp_* visible in cycle T+4).
- Throughput: one op per 4 cycles. A new ack can occur in the same cycle as the previous done.
- rsp_* hold their value until the next CAPTURE. Flags the ALU did not update (e.g. AND) are captured as presented by the ALU.
- Requester may change operands after ack. Requester may drop req before ack (withdrawal); no ack is issued.
- A req that stays high while busy is not acked until IDLE; ack never occurs outside IDLE.
- Port 1 losing a tie is granted on the next IDLE if still requesting, so no starvation.
- rst asserted mid-operation aborts it: no done, alu_op forced to 0 immediately, last_grant=1.
- ack, done and err are single-cycle pulses and never asserted for both ports in the same cycle.

Test Plan:
- Single add: r0 req, a=16'h0005, b=16'h0003, op=8'h01 -> r0_ack at T; alu_op=8'h01 only at T+1; r0_done at T+4 with rsp_acc=16'h0008, rsp_zf=0, rsp_id=0.
- Tie: both req in the same cycle after reset (r0 op ADD 1+1, r1 op SUB 5-5) -> r0 acked first, done rsp_acc=2; r1 acked in the cycle of r0_done, later done with rsp_acc=0, rsp_zf=1, rsp_id=1.
- Round-robin fairness: both req held continuously for 6 ops -> grants alternate 0,1,0,1,0,1; each done exactly 4 cycles after its ack.
- Illegal opcodes: r1 op=8'h00, then op=8'h12 -> r1_ack and r1_err in the same cycle, busy stays 0, alu_op stays 0, rsp_* unchanged.
- Carry path: r0 ADC a=16'hFFFF, b=16'h0000, cf=1 -> alu_cf=1 during ISSUE, rsp_acc=16'h0000, rsp_zf=1.
- Reset mid-op: assert rst at T+2 of an r0 MUL6 -> outputs 0 immediately, no r0_done; after release, r0 wins a tie again.
